pll_rst_seq: RTL and testbench

Reset and lock sequencer paired with the MMCM clock generator. It drives the MMCM reset, then qualifies the asynchronous MMCM lock indication with a two-flop synchronizer and a stability window. Once lock is proven it releases two staggered downstream resets: peripheral first, then core. It runs on the free-running board clock so it keeps working when the MMCM output clock is absent. It recovers automatically from lock timeout and from lock loss.

---
 rtl/pll_rst_seq.sv | 149 ++++++++++++++
 tb/tb_pll_rst_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// MMCM reset/lock sequencer: pulses the MMCM reset, qualifies LOCKED, then releases
// peripheral and core resets in a staggered order. Runs on the free-running board clock.
module pll_rst_seq #(
    parameter int unsigned MMCM_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned RELEASE_STAGGER     = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_locked,
    output logic       o_mmcm_rst,
    output logic       o_rst_periph,
    output logic       o_rst_core,
    output logic       o_ready,
    output logic [7:0] o_retry_cnt,
    output logic [7:0] o_loss_cnt
);

    localparam int unsigned MAX_AB = (MMCM_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                     MMCM_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CD = (LOCK_TIMEOUT_CYCLES > RELEASE_STAGGER) ?
                                     LOCK_TIMEOUT_CYCLES : RELEASE_STAGGER;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(MMCM_RST_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(RELEASE_STAGGER - 1);

    typedef enum logic [2:0] {
        ST_MMCM_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_lk;
    logic             w_retry_inc;
    logic             w_loss_inc;

    // Two-flop synchronizer; r_lk is the only view of LOCKED the sequencer uses
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_lk    <= 1'b0;
        end else begin
            r_sync1 <= i_locked;
            r_lk    <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_MMCM_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Lock wins over timeout in WAIT_LOCK; lock loss wins over stagger completion
    always_comb begin
        w_next_state = r_state;
        w_retry_inc  = 1'b0;
        w_loss_inc   = 1'b0;
        case (r_state)
            ST_MMCM_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_next_state = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (r_lk) begin
                    w_next_state = ST_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_next_state = ST_MMCM_RST;
                    w_retry_inc  = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!r_lk) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!r_lk) begin
                    w_next_state = ST_MMCM_RST;
                    w_loss_inc   = 1'b1;
                end else if (r_cnt == STAGGER_LAST) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!r_lk) begin
                    w_next_state = ST_MMCM_RST;
                    w_loss_inc   = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_MMCM_RST;
            end
        endcase
    end

    // Shared cycle counter: clears on any transition, idles in RUN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (r_state != ST_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Outputs decoded from the next state so they change on the transition edge
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_mmcm_rst   <= 1'b1;
            o_rst_periph <= 1'b1;
            o_rst_core   <= 1'b1;
            o_ready      <= 1'b0;
            o_retry_cnt  <= 8'd0;
            o_loss_cnt   <= 8'd0;
        end else begin
            o_mmcm_rst   <= (w_next_state == ST_MMCM_RST);
            o_rst_periph <= (w_next_state == ST_MMCM_RST) ||
                            (w_next_state == ST_WAIT_LOCK) ||
                            (w_next_state == ST_STABLE);
            o_rst_core   <= (w_next_state != ST_RUN);
            o_ready      <= (w_next_state == ST_RUN);
            if (w_retry_inc && (o_retry_cnt != 8'hFF)) begin
                o_retry_cnt <= o_retry_cnt + 8'd1;
            end
            if (w_loss_inc && (o_loss_cnt != 8'hFF)) begin
                o_loss_cnt <= o_loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: bring-up vector table, hand-written corner sequences and
// randomized LOCKED/reset stimulus compared every edge against an elapsed-time phase model.
module tb_pll_rst_seq;

    localparam int unsigned M = 4;
    localparam int unsigned L = 8;
    localparam int unsigned T = 32;
    localparam int unsigned S = 3;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_locked;
    logic       o_mmcm_rst;
    logic       o_rst_periph;
    logic       o_rst_core;
    logic       o_ready;
    logic [7:0] o_retry_cnt;
    logic [7:0] o_loss_cnt;

    pll_rst_seq #(
        .MMCM_RST_CYCLES    (M),
        .LOCK_STABLE_CYCLES (L),
        .LOCK_TIMEOUT_CYCLES(T),
        .RELEASE_STAGGER    (S)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_locked    (i_locked),
        .o_mmcm_rst  (o_mmcm_rst),
        .o_rst_periph(o_rst_periph),
        .o_rst_core  (o_rst_core),
        .o_ready     (o_ready),
        .o_retry_cnt (o_retry_cnt),
        .o_loss_cnt  (o_loss_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef enum int {PH_RST, PH_WAIT, PH_STABLE, PH_RELEASE, PH_RUN} phase_e;
    typedef struct {
        int         edge_i;
        logic       lock;
        logic [3:0] exp;   // {mmcm_rst, rst_periph, rst_core, ready}
    } vec_t;

    vec_t   vec [18];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     edge_n = 0;
    int     last_edge = 0;

    phase_e m_ph;
    int     m_entry;
    int     m_n;
    int     m_retry;
    int     m_loss;
    logic   m_q [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, last_edge, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph    = PH_RST;
        m_entry = -1;
        m_n     = 0;
        m_retry = 0;
        m_loss  = 0;
        m_q.delete();
        m_q.push_back(1'b0);
        m_q.push_back(1'b0);
    endtask

    // Phase model: lk is LOCKED sampled two edges earlier; phase exits are measured
    // as edges elapsed since the phase was entered.
    task automatic model_step(input logic smp);
        logic lk;
        int   el;
        lk = m_q.pop_front();
        m_q.push_back(smp);
        el = m_n - m_entry;
        case (m_ph)
            PH_RST: if (el == int'(M) + 1) begin m_ph = PH_WAIT; m_entry = m_n; end
            PH_WAIT: begin
                if (lk) begin
                    m_ph = PH_STABLE; m_entry = m_n;
                end else if (el == int'(T)) begin
                    m_ph = PH_RST; m_entry = m_n;
                    if (m_retry < 255) m_retry++;
                end
            end
            PH_STABLE: begin
                if (!lk) begin
                    m_ph = PH_WAIT; m_entry = m_n;
                end else if (el == int'(L)) begin
                    m_ph = PH_RELEASE; m_entry = m_n;
                end
            end
            PH_RELEASE: begin
                if (!lk) begin
                    m_ph = PH_RST; m_entry = m_n;
                    if (m_loss < 255) m_loss++;
                end else if (el == int'(S)) begin
                    m_ph = PH_RUN; m_entry = m_n;
                end
            end
            default: begin
                if (!lk) begin
                    m_ph = PH_RST; m_entry = m_n;
                    if (m_loss < 255) m_loss++;
                end
            end
        endcase
        m_n++;
    endtask

    task automatic check_model();
        chk("model mmcm_rst",   8'(o_mmcm_rst),   8'(m_ph == PH_RST));
        chk("model rst_periph", 8'(o_rst_periph),
            8'(m_ph == PH_RST || m_ph == PH_WAIT || m_ph == PH_STABLE));
        chk("model rst_core",   8'(o_rst_core),   8'(m_ph != PH_RUN));
        chk("model ready",      8'(o_ready),      8'(m_ph == PH_RUN));
        chk("model retry_cnt",  o_retry_cnt,      8'(m_retry));
        chk("model loss_cnt",   o_loss_cnt,       8'(m_loss));
    endtask

    // One clock: drive LOCKED just after the previous edge, sample 1 ns after this edge
    task automatic tick(input logic lock);
        i_locked = lock;
        @(posedge i_clk);
        if (!i_reset) model_step(lock);
        last_edge = edge_n;
        edge_n++;
        #1;
        check_model();
    endtask

    task automatic ticks_to(input int e, input logic lock);
        while (edge_n <= e) tick(lock);
    endtask

    task automatic chk_outs(input string name, input logic [3:0] exp);
        chk(name, 8'({o_mmcm_rst, o_rst_periph, o_rst_core, o_ready}), 8'(exp));
    endtask

    task automatic apply_reset();
        i_reset = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'(i % 2));
            chk_outs("reset outs", 4'b1110);
            chk("reset retry", o_retry_cnt, 8'd0);
            chk("reset loss", o_loss_cnt, 8'd0);
        end
        i_reset = 1'b0;
        model_reset();
        edge_n = 0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 18; i++) begin
            tick(vec[i].lock);
            chk_outs($sformatf("bringup e%0d", vec[i].edge_i), vec[i].exp);
            chk("bringup retry", o_retry_cnt, 8'd0);
            chk("bringup loss", o_loss_cnt, 8'd0);
        end
    endtask

    initial begin
        for (int e = 0; e < 18; e++) vec[e].lock = 1'b1;
        vec[0]  = '{0,  1'b1, 4'b1110};  vec[1]  = '{1,  1'b1, 4'b1110};
        vec[2]  = '{2,  1'b1, 4'b1110};  vec[3]  = '{3,  1'b1, 4'b1110};
        vec[4]  = '{4,  1'b1, 4'b0110};  vec[5]  = '{5,  1'b1, 4'b0110};
        vec[6]  = '{6,  1'b1, 4'b0110};  vec[7]  = '{7,  1'b1, 4'b0110};
        vec[8]  = '{8,  1'b1, 4'b0110};  vec[9]  = '{9,  1'b1, 4'b0110};
        vec[10] = '{10, 1'b1, 4'b0110};  vec[11] = '{11, 1'b1, 4'b0110};
        vec[12] = '{12, 1'b1, 4'b0110};  vec[13] = '{13, 1'b1, 4'b0010};
        vec[14] = '{14, 1'b1, 4'b0010};  vec[15] = '{15, 1'b1, 4'b0010};
        vec[16] = '{16, 1'b1, 4'b0001};  vec[17] = '{17, 1'b1, 4'b0001};

        i_reset  = 1'b1;
        i_locked = 1'b0;
        model_reset();

        // Reset values with LOCKED toggling, then clean bring-up
        apply_reset();
        run_table();

        // Timeout retry and retry-count saturation
        apply_reset();
        ticks_to(35, 1'b0);
        chk("timeout mmcm before", 8'(o_mmcm_rst), 8'd0);
        ticks_to(36, 1'b0);
        chk("timeout mmcm rise", 8'(o_mmcm_rst), 8'd1);
        chk("timeout retry 1", o_retry_cnt, 8'd1);
        for (int i = 0; i < 300 * int'(M + 1 + T); i++) tick(1'b0);
        chk("retry saturated", o_retry_cnt, 8'd255);
        for (int i = 0; i < 2 * int'(M + 1 + T); i++) tick(1'b0);
        chk("retry holds", o_retry_cnt, 8'd255);

        // Single-cycle glitch in STABLE restarts the window
        apply_reset();
        ticks_to(6, 1'b1);
        tick(1'b0);
        ticks_to(17, 1'b1);
        chk("glitch periph held", 8'(o_rst_periph), 8'd1);
        ticks_to(18, 1'b1);
        chk_outs("glitch periph release", 4'b0010);
        ticks_to(20, 1'b1);
        chk("glitch core held", 8'(o_rst_core), 8'd1);
        ticks_to(21, 1'b1);
        chk_outs("glitch run", 4'b0001);

        // Lock loss in RUN, then relock
        ticks_to(24, 1'b1);
        ticks_to(26, 1'b0);
        chk("loss p+1 ready", 8'(o_ready), 8'd1);
        ticks_to(27, 1'b0);
        chk_outs("loss p+2 outs", 4'b1110);
        chk("loss cnt", o_loss_cnt, 8'd1);
        ticks_to(31, 1'b1);
        chk("relock mmcm held", 8'(o_mmcm_rst), 8'd1);
        ticks_to(32, 1'b1);
        chk("relock mmcm fall", 8'(o_mmcm_rst), 8'd0);
        ticks_to(40, 1'b1);
        chk("relock periph held", 8'(o_rst_periph), 8'd1);
        ticks_to(41, 1'b1);
        chk_outs("relock periph fall", 4'b0010);
        chk("relock loss cnt", o_loss_cnt, 8'd1);
        ticks_to(42, 1'b1);

        // Asynchronous reset during RELEASE
        #2;
        i_reset = 1'b1;
        model_reset();
        #1;
        chk_outs("async reset outs", 4'b1110);
        chk("async reset loss", o_loss_cnt, 8'd0);
        chk("async reset retry", o_retry_cnt, 8'd0);
        tick(1'b1);
        tick(1'b1);
        i_reset = 1'b0;
        model_reset();
        edge_n = 0;
        run_table();

        // Randomized LOCKED segments with occasional async reset pulses
        for (int seg = 0; seg < 160; seg++) begin
            logic lv;
            int   len;
            if ($urandom_range(0, 24) == 0) begin
                #2;
                i_reset = 1'b1;
                model_reset();
                #1;
                check_model();
                tick(1'($urandom_range(0, 1)));
                i_reset = 1'b0;
                model_reset();
                edge_n = 0;
            end
            lv  = ($urandom_range(0, 3) != 0);
            len = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 40));
            for (int k = 0; k < len; k++) tick(lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
